ram_arbiter: RTL and testbench

Fair arbiter that shares the single RAM port among the instruction and data caches of `CPUS` cores. It replaces fixed-priority muxing with a registered grant. The grant is held for a whole RAM transaction and rotates round-robin across cores. It sits between the per-core cache controllers (cache-side `ccif` signals) and the RAM model, alongside coherence control.

---
 rtl/ram_arbiter_pkg.sv | 45 ++++
 rtl/ram_arbiter_if.sv | 45 ++++
 rtl/ram_arbiter_rr_picker.sv | 34 +++
 rtl/ram_arbiter.sv | 124 ++++++++++++
 tb/tb_ram_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_arbiter_pkg.sv
// rtl/ram_arbiter_pkg.sv - shared types for the round-robin RAM arbiter
// Contents:
//   word_t      32-bit bus word used for addresses and data
//   ramstate_t  status reported by the RAM model each cycle
//   arb_state_t arbiter FSM states
//   arb_src_t   requester inside a core, listed in service priority order
//   pick_src    chooses the highest-priority active source of one core
package ram_arbiter_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE,
        BUSY,
        ACCESS,
        ERROR
    } ramstate_t;

    typedef enum logic {
        IDLE,
        GRANT
    } arb_state_t;

    typedef enum logic [1:0] {
        SRC_DW,
        SRC_DR,
        SRC_I
    } arb_src_t;

    // A write is served before a data read, which is served before a fetch.
    // Called only for a core known to have some request, so SRC_I is the
    // fall-through.
    function automatic arb_src_t pick_src(input logic dw, input logic dr);
        if (dw) begin
            return SRC_DW;
        end
        if (dr) begin
            return SRC_DR;
        end
        return SRC_I;
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// rtl/ram_arbiter_if.sv - cache-side and RAM-side signal bundle of the arbiter
// Signals (CPUS cores, one icache and one dcache requester each):
//   iREN/dREN/dWEN  per-core request lines         (caches -> arbiter)
//   iaddr/daddr     per-core addresses             (caches -> arbiter)
//   dstore          per-core write data            (caches -> arbiter)
//   iwait/dwait     per-core stalls, low on done   (arbiter -> caches)
//   iload/dload     per-core read data             (arbiter -> caches)
//   ramREN/ramWEN, ramaddr, ramstore               (arbiter -> RAM)
//   ramload, ramstate                              (RAM -> arbiter)
// Modports: slave is the arbiter, master is the cache/RAM environment.
interface ram_arbiter_if
    import ram_arbiter_pkg::*;
#(
    parameter int CPUS = 2
);

    logic [CPUS-1:0]  iREN;
    logic [CPUS-1:0]  dREN;
    logic [CPUS-1:0]  dWEN;
    word_t [CPUS-1:0] iaddr;
    word_t [CPUS-1:0] daddr;
    word_t [CPUS-1:0] dstore;
    logic [CPUS-1:0]  iwait;
    logic [CPUS-1:0]  dwait;
    word_t [CPUS-1:0] iload;
    word_t [CPUS-1:0] dload;

    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;

    modport slave (
        input  iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate,
        output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate,
        input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
    );

endinterface

// File: rtl/ram_arbiter_rr_picker.sv
// rtl/ram_arbiter_rr_picker.sv - combinational round-robin winner selection
// Ports:
//   req  in   CPUS  per-core "has any request" vector
//   rr   in   IDXW  core the scan starts from
//   win  out  IDXW  first requesting core at or after rr, wrapping
//   any  out  1     at least one core is requesting
module ram_arbiter_rr_picker #(
    parameter int CPUS = 2,
    parameter int IDXW = 1
) (
    input  logic [CPUS-1:0] req,
    input  logic [IDXW-1:0] rr,
    output logic [IDXW-1:0] win,
    output logic            any
);

    logic [IDXW-1:0] idx;

    // Walk from the farthest offset back to rr so the last hit, which is the
    // one closest to rr in scan order, is the one left in win.
    always_comb begin
        win = '0;
        any = 1'b0;
        idx = '0;
        for (int i = CPUS - 1; i >= 0; i--) begin
            idx = IDXW'((int'(rr) + i) % CPUS);
            if (req[idx]) begin
                win = idx;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - round-robin arbiter sharing one RAM port among CPUS cores
// Ports:
//   CLK      in   system clock, rising edge
//   nRST     in   asynchronous active-low reset
//   ccif     slave modport of ram_arbiter_if (cache requests, waits, RAM port)
//   gnt_cpu  out  core holding the grant, meaningful while in GRANT
// A winner is registered in IDLE and keeps the RAM for one whole transaction;
// completion moves the round-robin pointer past the winner, an abort does not.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter  int CPUS = 2,
    localparam int IDXW = (CPUS > 1) ? $clog2(CPUS) : 1
) (
    input  logic            CLK,
    input  logic            nRST,
    ram_arbiter_if.slave    ccif,
    output logic [IDXW-1:0] gnt_cpu
);

    arb_state_t      state;
    arb_src_t        gnt_src;
    logic [IDXW-1:0] rr;
    logic [IDXW-1:0] rr_next;
    logic [IDXW-1:0] win;
    logic            any_req;
    logic [CPUS-1:0] req;
    logic            gnt_live;
    logic            active;
    logic            done;

    assign req = ccif.iREN | ccif.dREN | ccif.dWEN;

    ram_arbiter_rr_picker #(
        .CPUS (CPUS),
        .IDXW (IDXW)
    ) u_rr_picker (
        .req (req),
        .rr  (rr),
        .win (win),
        .any (any_req)
    );

    // The granted request line itself; dropping it mid-transaction aborts.
    always_comb begin
        case (gnt_src)
            SRC_DW:  gnt_live = ccif.dWEN[gnt_cpu];
            SRC_DR:  gnt_live = ccif.dREN[gnt_cpu];
            SRC_I:   gnt_live = ccif.iREN[gnt_cpu];
            default: gnt_live = 1'b0;
        endcase
    end

    assign active  = (state == GRANT) && gnt_live;
    assign done    = active && (ccif.ramstate == ACCESS);
    assign rr_next = (int'(gnt_cpu) == CPUS - 1) ? '0 : gnt_cpu + 1'b1;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state   <= IDLE;
            rr      <= '0;
            gnt_cpu <= '0;
            gnt_src <= SRC_I;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt_cpu <= win;
                        gnt_src <= pick_src(ccif.dWEN[win], ccif.dREN[win]);
                        state   <= GRANT;
                    end
                end
                GRANT: begin
                    if (!gnt_live) begin
                        state <= IDLE;
                    end else if (ccif.ramstate == ACCESS) begin
                        state <= IDLE;
                        rr    <= rr_next;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // RAM drive and wait release follow the registered grant combinationally
    // so the requester sees its wait drop on the very ACCESS cycle.
    always_comb begin
        ccif.ramREN   = 1'b0;
        ccif.ramWEN   = 1'b0;
        ccif.ramaddr  = '0;
        ccif.ramstore = '0;
        ccif.iwait    = '1;
        ccif.dwait    = '1;
        if (active) begin
            case (gnt_src)
                SRC_DW: begin
                    ccif.ramWEN   = 1'b1;
                    ccif.ramaddr  = ccif.daddr[gnt_cpu];
                    ccif.ramstore = ccif.dstore[gnt_cpu];
                end
                SRC_DR: begin
                    ccif.ramREN  = 1'b1;
                    ccif.ramaddr = ccif.daddr[gnt_cpu];
                end
                default: begin
                    ccif.ramREN  = 1'b1;
                    ccif.ramaddr = ccif.iaddr[gnt_cpu];
                end
            endcase
        end
        if (done) begin
            if (gnt_src == SRC_I) begin
                ccif.iwait[gnt_cpu] = 1'b0;
            end else begin
                ccif.dwait[gnt_cpu] = 1'b0;
            end
        end
    end

    assign ccif.iload = {CPUS{ccif.ramload}};
    assign ccif.dload = {CPUS{ccif.ramload}};

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - scoreboard bench for ram_arbiter
module tb_ram_arbiter;
    import ram_arbiter_pkg::*;

    localparam int    CPUS = 2;
    localparam int    IW   = 1;
    localparam word_t K    = 32'h5A5A_0F0F;

    // src: 0 data write, 1 data read, 2 instruction fetch
    typedef struct {
        int    cpu;
        int    src;
        word_t addr;
        bit    we;
        word_t data;
    } exp_t;

    logic          clk  = 1'b0;
    logic          nrst = 1'b1;
    logic [IW-1:0] gnt_cpu;

    ram_arbiter_if #(.CPUS(CPUS)) bus ();

    ram_arbiter #(.CPUS(CPUS)) dut (
        .CLK     (clk),
        .nRST    (nrst),
        .ccif    (bus),
        .gnt_cpu (gnt_cpu)
    );

    always #5 clk = ~clk;

    // RAM stand-in: read data is a fixed scramble of the address.
    assign bus.ramload = bus.ramaddr ^ K;

    int    n_cmp     = 0;
    int    n_fail    = 0;
    int    cyc       = 0;
    int    last_done = -10;
    int    m_rr      = 0;
    bit    hold      = 1'b0;
    bit    ram_auto  = 1'b0;
    exp_t  exq[$];
    bit [2:0] pend [CPUS];   // bit0 dWEN, bit1 dREN, bit2 iREN
    word_t ia [CPUS];
    word_t da [CPUS];
    word_t ds [CPUS];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply();
        for (int c = 0; c < CPUS; c++) begin
            bus.dWEN[c]   = pend[c][0];
            bus.dREN[c]   = pend[c][1];
            bus.iREN[c]   = pend[c][2];
            bus.iaddr[c]  = ia[c];
            bus.daddr[c]  = da[c];
            bus.dstore[c] = ds[c];
        end
    endtask

    // Reference order: from the pointer, the first core with anything pending
    // is served, write before read before fetch; pointer moves past it.
    task automatic plan();
        int   c;
        int   s;
        int   t;
        bit   more;
        exp_t e;
        more = 1'b1;
        while (more) begin
            c = -1;
            for (int k = CPUS - 1; k >= 0; k--) begin
                t = (m_rr + k) % CPUS;
                if (pend[t] != 3'b000) c = t;
            end
            if (c < 0) begin
                more = 1'b0;
            end else begin
                s = pend[c][0] ? 0 : (pend[c][1] ? 1 : 2);
                pend[c][s] = 1'b0;
                e.cpu  = c;
                e.src  = s;
                e.addr = (s == 2) ? ia[c] : da[c];
                e.we   = (s == 0);
                e.data = (s == 0) ? ds[c] : (e.addr ^ K);
                exq.push_back(e);
                m_rr = (c + 1) % CPUS;
            end
        end
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while ((exq.size() != 0 || (bus.iREN | bus.dREN | bus.dWEN) != '0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(name, exq.size(), 0);
        exq.delete();
        bus.iREN = '0;
        bus.dREN = '0;
        bus.dWEN = '0;
    endtask

    task automatic rand_round();
        int d;
        for (int c = 0; c < CPUS; c++) begin
            d       = $urandom_range(0, 2);
            pend[c] = {1'($urandom_range(0, 1)), d == 1, d == 2};
            ia[c]   = $urandom;
            da[c]   = $urandom;
            ds[c]   = $urandom;
        end
        if (pend[0] == 3'b000 && pend[1] == 3'b000) pend[$urandom_range(0, CPUS - 1)] = 3'b100;
        apply();
        plan();
        drain("round_drain", 400);
    endtask

    // RAM status generator
    initial forever begin
        int r;
        @(posedge clk);
        #1;
        if (ram_auto) begin
            r = $urandom_range(0, 9);
            bus.ramstate = (r < 4) ? ACCESS : (r < 6) ? FREE : (r < 8) ? BUSY : ERROR;
        end
    end

    // Requester model: drops a served line right after its completing edge.
    initial forever begin
        logic [CPUS-1:0] di;
        logic [CPUS-1:0] dd;
        logic            w;
        @(negedge clk);
        di = ~bus.iwait;
        dd = ~bus.dwait;
        w  = bus.ramWEN;
        @(posedge clk);
        #1;
        if (!hold) begin
            bus.iREN = bus.iREN & ~di;
            if (w) bus.dWEN = bus.dWEN & ~dd;
            else   bus.dREN = bus.dREN & ~dd;
        end
    end

    // Scoreboard monitor
    initial forever begin
        logic [CPUS-1:0] lo_i;
        logic [CPUS-1:0] lo_d;
        logic [CPUS-1:0] ew;
        exp_t            e;
        @(negedge clk);
        lo_i = ~bus.iwait;
        lo_d = ~bus.dwait;
        if ((lo_i | lo_d) != '0) begin
            chk("bubble_gap", (cyc - last_done) >= 2, 1'b1);
            last_done = cyc;
            if (exq.size() == 0) begin
                chk("spurious_release", {lo_i, lo_d}, '0);
            end else begin
                e  = exq.pop_front();
                ew = '0;
                ew[e.cpu] = 1'b1;
                chk("done_iwait", lo_i, (e.src == 2) ? ew : '0);
                chk("done_dwait", lo_d, (e.src != 2) ? ew : '0);
                chk("done_addr", bus.ramaddr, e.addr);
                chk("done_wen", bus.ramWEN, e.we);
                chk("done_ren", bus.ramREN, !e.we);
                if (e.we) chk("done_store", bus.ramstore, e.data);
                else chk("done_load", (e.src == 2) ? bus.iload[e.cpu] : bus.dload[e.cpu], e.data);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.iREN = '0; bus.dREN = '0; bus.dWEN = '0;
        bus.iaddr = '0; bus.daddr = '0; bus.dstore = '0;
        bus.ramstate = FREE;
        for (int c = 0; c < CPUS; c++) begin
            pend[c] = 3'b000; ia[c] = '0; da[c] = '0; ds[c] = '0;
        end
        #1 nrst = 1'b0;
        repeat (2) tick();
        chk("rst_ren", bus.ramREN, 1'b0);
        chk("rst_wen", bus.ramWEN, 1'b0);
        chk("rst_addr", bus.ramaddr, 32'h0);
        chk("rst_store", bus.ramstore, 32'h0);
        chk("rst_iwait", bus.iwait, 2'b11);
        chk("rst_dwait", bus.dwait, 2'b11);
        chk("rst_gnt", gnt_cpu, 1'b0);
        nrst = 1'b1;
        tick();

        // Minimum-latency data read on core 0, ACCESS on second grant cycle
        pend[0] = 3'b010; da[0] = 32'h40;
        apply();
        plan();
        @(negedge clk);
        chk("lat_c0_ren", bus.ramREN, 1'b0);
        tick(); bus.ramstate = BUSY;
        @(negedge clk);
        chk("lat_c1_ren", bus.ramREN, 1'b1);
        chk("lat_c1_addr", bus.ramaddr, 32'h40);
        chk("lat_c1_dwait", bus.dwait, 2'b11);
        tick(); bus.ramstate = ACCESS;
        @(negedge clk);
        chk("lat_c2_ren", bus.ramREN, 1'b1);
        chk("lat_c2_dwait", bus.dwait, 2'b10);
        chk("lat_c2_iwait", bus.iwait, 2'b11);
        tick(); bus.ramstate = FREE;
        @(negedge clk);
        chk("lat_c3_ren", bus.ramREN, 1'b0);
        chk("lat_c3_dwait", bus.dwait, 2'b11);
        drain("lat_drain", 20);

        // All three sources of core 0 at once
        ram_auto = 1'b1;
        pend[0] = 3'b111; pend[1] = 3'b000;
        ia[0] = $urandom; da[0] = $urandom; ds[0] = $urandom;
        apply();
        plan();
        drain("prio_drain", 200);

        // Both fetches held continuously, RAM always ready
        ram_auto = 1'b0; tick(); bus.ramstate = ACCESS; hold = 1'b1;
        pend[0] = 3'b100; pend[1] = 3'b100; ia[0] = 32'h1000; ia[1] = 32'h2000;
        apply();
        for (int k = 0; k < 4; k++) begin
            exp_t e;
            e.cpu = m_rr; e.src = 2; e.addr = ia[m_rr]; e.we = 1'b0; e.data = ia[m_rr] ^ K;
            exq.push_back(e);
            m_rr = (m_rr + 1) % CPUS;
        end
        n = 0;
        while (exq.size() != 0 && n < 40) begin @(posedge clk); n++; end
        #1;
        bus.iREN = '0; hold = 1'b0;
        chk("hold_q", exq.size(), 0);
        exq.delete();
        bus.ramstate = FREE;
        pend[0] = 3'b000; pend[1] = 3'b000;
        tick();

        // Abort: core 1 write dropped while RAM busy; pointer must stay
        pend[0] = 3'b100; ia[0] = 32'h3000;
        apply(); plan(); ram_auto = 1'b1;
        drain("pre_abort_drain", 200);
        ram_auto = 1'b0; tick(); bus.ramstate = BUSY;
        pend[0] = 3'b000; pend[1] = 3'b001; da[1] = 32'h77C; ds[1] = 32'hCAFE_F00D;
        apply();
        tick();
        @(negedge clk);
        chk("abort_wen_on", bus.ramWEN, 1'b1);
        chk("abort_gnt", gnt_cpu, 1'b1);
        tick(); bus.dWEN[1] = 1'b0;
        @(negedge clk);
        chk("abort_wen_off", bus.ramWEN, 1'b0);
        chk("abort_dwait", bus.dwait, 2'b11);
        tick();
        pend[0] = 3'b100; pend[1] = 3'b001;
        apply(); plan(); ram_auto = 1'b1;
        drain("post_abort_drain", 200);

        // RAM ERROR retried three cycles before ACCESS
        ram_auto = 1'b0; tick(); bus.ramstate = ERROR;
        pend[0] = 3'b100; pend[1] = 3'b000; ia[0] = 32'h5000;
        apply(); plan();
        tick();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("err_iwait", bus.iwait, 2'b11);
            chk("err_ren", bus.ramREN, 1'b1);
            tick();
        end
        bus.ramstate = ACCESS;
        @(negedge clk);
        chk("err_release", bus.iwait, 2'b10);
        tick(); bus.ramstate = FREE;
        drain("err_drain", 20);

        // Reset in the middle of a core 1 grant
        bus.ramstate = BUSY;
        pend[0] = 3'b000; pend[1] = 3'b001; da[1] = 32'h900; ds[1] = 32'h1234_5678;
        apply();
        tick();
        @(negedge clk);
        chk("rstmid_gnt", gnt_cpu, 1'b1);
        #2 nrst = 1'b0;
        #1;
        chk("rstmid_wen", bus.ramWEN, 1'b0);
        chk("rstmid_addr", bus.ramaddr, 32'h0);
        chk("rstmid_store", bus.ramstore, 32'h0);
        chk("rstmid_dwait", bus.dwait, 2'b11);
        chk("rstmid_iwait", bus.iwait, 2'b11);
        chk("rstmid_gnt0", gnt_cpu, 1'b0);
        m_rr = 0;
        pend[0] = 3'b100; ia[0] = 32'h6000;
        apply();
        tick();
        nrst = 1'b1; ram_auto = 1'b1;
        plan();
        drain("rstmid_drain", 200);

        for (int r = 0; r < 30; r++) rand_round();

        $display("End of test - %0d assertions evaluated, %0d failures", n_cmp, n_fail);
        $finish;
    end

endmodule
